spsram_swap_ctrl: RTL and testbench

Sequencer and access arbiter for a pair of single-port SRAM banks (A and B, `spsram` instances of equal DEPTH×WIDTH). On `start` it exchanges the contents of the two banks address by address, using read-then-cross-write pairs. While idle it passes a single host port through to either bank. The block sits between the host and the two `spsram` instances and is the only driver of their pins.

---
 rtl/spsram_swap_pkg.sv | 14 +
 rtl/spsram.sv | 24 ++
 rtl/spsram_swap_top.sv | 49 ++++
 rtl/spsram_swap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_spsram_swap_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spsram_swap_pkg.sv
// Shared types for the single-port SRAM swap controller: FSM states and bank ids.
package spsram_swap_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

endpackage

// File: rtl/spsram.sv
// Single-port synchronous SRAM: write when cs&we, registered read data one cycle after cs&~we.
module spsram #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 cs,
  input  logic                 we,
  input  logic [DEPTH_LOG-1:0] ad,
  input  logic [WIDTH-1:0]     wd,
  output logic [WIDTH-1:0]     rd
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (cs) begin
      if (we) mem[ad] <= wd;
      else    rd      <= mem[ad];
    end
  end

endmodule

// File: rtl/spsram_swap_top.sv
// Integration wrapper: swap controller plus its two spsram banks (SWAP_RANGE_EN adds sw_lo/sw_hi).
module spsram_swap_top #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
`ifdef SWAP_RANGE_EN
  input  logic [DEPTH_LOG-1:0] sw_lo,
  input  logic [DEPTH_LOG-1:0] sw_hi,
`endif
  input  logic                 h_req,
  input  logic                 h_sel,
  input  logic                 h_we,
  input  logic [DEPTH_LOG-1:0] h_ad,
  input  logic [WIDTH-1:0]     h_wd,
  output logic                 h_gnt,
  output logic [WIDTH-1:0]     h_rd,
  output logic                 h_rvalid
);

  logic                 cs_a, we_a, cs_b, we_b;
  logic [DEPTH_LOG-1:0] ad_a, ad_b;
  logic [WIDTH-1:0]     wd_a, wd_b, rd_a, rd_b;

  spsram_swap_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) u_ctrl (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
`ifdef SWAP_RANGE_EN
    .sw_lo(sw_lo), .sw_hi(sw_hi),
`endif
    .h_req(h_req), .h_sel(h_sel), .h_we(h_we), .h_ad(h_ad), .h_wd(h_wd),
    .h_gnt(h_gnt), .h_rd(h_rd), .h_rvalid(h_rvalid),
    .cs_a(cs_a), .we_a(we_a), .ad_a(ad_a), .wd_a(wd_a), .rd_a(rd_a),
    .cs_b(cs_b), .we_b(we_b), .ad_b(ad_b), .wd_b(wd_b), .rd_b(rd_b)
  );

  spsram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) u_bank_a (
    .clk(clk), .cs(cs_a), .we(we_a), .ad(ad_a), .wd(wd_a), .rd(rd_a)
  );

  spsram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(DEPTH_LOG)) u_bank_b (
    .clk(clk), .cs(cs_b), .we(we_b), .ad(ad_b), .wd(wd_b), .rd(rd_b)
  );

endmodule

// File: rtl/spsram_swap_ctrl.sv
// Swap sequencer and host arbiter for two single-port SRAM banks.
// Optional macro SWAP_RANGE_EN adds sw_lo/sw_hi to restrict the swapped address range.
module spsram_swap_ctrl
  import spsram_swap_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 32,
  parameter int DEPTH_LOG = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
`ifdef SWAP_RANGE_EN
  input  logic [DEPTH_LOG-1:0] sw_lo,
  input  logic [DEPTH_LOG-1:0] sw_hi,
`endif
  input  logic                 h_req,
  input  logic                 h_sel,
  input  logic                 h_we,
  input  logic [DEPTH_LOG-1:0] h_ad,
  input  logic [WIDTH-1:0]     h_wd,
  output logic                 h_gnt,
  output logic [WIDTH-1:0]     h_rd,
  output logic                 h_rvalid,
  output logic                 cs_a,
  output logic                 we_a,
  output logic [DEPTH_LOG-1:0] ad_a,
  output logic [WIDTH-1:0]     wd_a,
  input  logic [WIDTH-1:0]     rd_a,
  output logic                 cs_b,
  output logic                 we_b,
  output logic [DEPTH_LOG-1:0] ad_b,
  output logic [WIDTH-1:0]     wd_b,
  input  logic [WIDTH-1:0]     rd_b
);

  localparam logic [DEPTH_LOG-1:0] LAST = DEPTH_LOG'(DEPTH - 1);

  state_t               state;
  logic [DEPTH_LOG-1:0] addr;
  logic                 sel_q;
  logic                 host_go;
  logic [DEPTH_LOG-1:0] start_lo;
  logic [DEPTH_LOG-1:0] hi_lim;
  logic                 range_empty;

`ifdef SWAP_RANGE_EN
  logic [DEPTH_LOG-1:0] hi_q;
  assign start_lo    = sw_lo;
  assign hi_lim      = hi_q;
  assign range_empty = (sw_lo > sw_hi);
`else
  assign start_lo    = '0;
  assign hi_lim      = LAST;
  assign range_empty = 1'b0;
`endif

  // Host is served only in IDLE, never during reset, and loses to a same-cycle start.
  assign host_go = (state == IDLE) && h_req && !start && !rst;
  assign h_gnt   = host_go;
  assign h_rd    = (sel_q == BANK_B) ? rd_b : rd_a;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      h_rvalid <= 1'b0;
      sel_q    <= BANK_A;
`ifdef SWAP_RANGE_EN
      hi_q     <= LAST;
`endif
    end else begin
      h_rvalid <= host_go && !h_we;
      if (host_go) sel_q <= h_sel;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
`ifdef SWAP_RANGE_EN
            hi_q <= sw_hi;
`endif
            if (range_empty) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RD;
              addr  <= start_lo;
            end
          end
        end
        RD: state <= WR;
        WR: begin
          if (addr == hi_lim) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            addr  <= addr + 1'b1;
            state <= RD;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cs_a = 1'b0;
    we_a = 1'b0;
    ad_a = '0;
    wd_a = '0;
    cs_b = 1'b0;
    we_b = 1'b0;
    ad_b = '0;
    wd_b = '0;
    case (state)
      IDLE: begin
        if (host_go) begin
          if (h_sel == BANK_B) begin
            cs_b = 1'b1;
            we_b = h_we;
            ad_b = h_ad;
            wd_b = h_wd;
          end else begin
            cs_a = 1'b1;
            we_a = h_we;
            ad_a = h_ad;
            wd_a = h_wd;
          end
        end
      end
      RD: begin
        cs_a = 1'b1;
        cs_b = 1'b1;
        ad_a = addr;
        ad_b = addr;
      end
      // Read data from the previous RD cycle is cross-written in this cycle.
      WR: begin
        cs_a = 1'b1;
        cs_b = 1'b1;
        we_a = 1'b1;
        we_b = 1'b1;
        ad_a = addr;
        ad_b = addr;
        wd_a = rd_b;
        wd_b = rd_a;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_spsram_swap_ctrl.sv
// Self-checking bench for spsram_swap_ctrl driving two spsram banks; range tests need SWAP_RANGE_EN.
module tb_spsram_swap_ctrl;

  localparam int DEPTH = 8;
  localparam int WIDTH = 32;
  localparam int DL    = 3;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic h_req, h_sel, h_we, h_gnt, h_rvalid;
  logic [DL-1:0]    h_ad, ad_a, ad_b;
  logic [WIDTH-1:0] h_wd, h_rd, wd_a, wd_b, rd_a, rd_b;
  logic cs_a, we_a, cs_b, we_b;
`ifdef SWAP_RANGE_EN
  logic [DL-1:0] sw_lo, sw_hi;
`endif

  int tests = 0;
  int fails = 0;

  logic [WIDTH-1:0] ref_a [DEPTH];
  logic [WIDTH-1:0] ref_b [DEPTH];

  typedef struct {
    bit               sel;
    bit               we;
    logic [DL-1:0]    ad;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] exp_rd;
  } vec_t;

  vec_t vecs [32];

  always #5 clk = ~clk;

  spsram_swap_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(DL)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
`ifdef SWAP_RANGE_EN
    .sw_lo(sw_lo), .sw_hi(sw_hi),
`endif
    .h_req(h_req), .h_sel(h_sel), .h_we(h_we), .h_ad(h_ad), .h_wd(h_wd),
    .h_gnt(h_gnt), .h_rd(h_rd), .h_rvalid(h_rvalid),
    .cs_a(cs_a), .we_a(we_a), .ad_a(ad_a), .wd_a(wd_a), .rd_a(rd_a),
    .cs_b(cs_b), .we_b(we_b), .ad_b(ad_b), .wd_b(wd_b), .rd_b(rd_b)
  );

  spsram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(DL)) u_bank_a (
    .clk(clk), .cs(cs_a), .we(we_a), .ad(ad_a), .wd(wd_a), .rd(rd_a)
  );

  spsram #(.DEPTH(DEPTH), .WIDTH(WIDTH), .DEPTH_LOG(DL)) u_bank_b (
    .clk(clk), .cs(cs_b), .we(we_b), .ad(ad_b), .wd(wd_b), .rd(rd_b)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One host access, issued at a negedge; read data checked the following cycle.
  task automatic host_access(input bit sel, input bit we, input logic [DL-1:0] ad,
                             input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] exp,
                             input string tag);
    @(negedge clk);
    h_req = 1'b1; h_sel = sel; h_we = we; h_ad = ad; h_wd = wd;
    #1;
    chk({tag, "_gnt"}, h_gnt, 1);
    chk({tag, "_cs_sel"}, sel ? cs_b : cs_a, 1);
    chk({tag, "_cs_other"}, sel ? cs_a : cs_b, 0);
    chk({tag, "_ad"}, sel ? ad_b : ad_a, ad);
    @(negedge clk);
    h_req = 1'b0; h_we = 1'b0;
    chk({tag, "_rvalid"}, h_rvalid, !we);
    if (!we) chk({tag, "_rd"}, h_rd, exp);
    if (we) begin
      if (sel) ref_b[ad] = wd;
      else     ref_a[ad] = wd;
    end
  endtask

  task automatic read_all(input string tag);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < DEPTH; i++)
        host_access(s[0], 1'b0, i[DL-1:0], '0, (s == 1) ? ref_b[i] : ref_a[i], tag);
  endtask

  task automatic model_swap(input int lo, input int cnt);
    logic [WIDTH-1:0] t;
    for (int i = lo; i < lo + cnt; i++) begin
      t = ref_a[i]; ref_a[i] = ref_b[i]; ref_b[i] = t;
    end
  endtask

  // Start a swap of [lo,hi]; hq holds a host write of A[0]=0xFF throughout,
  // sec_start pulses a second start in that cycle, rst_at resets in that cycle.
  task automatic run_swap(input int lo, input int hi, input bit hq,
                          input int sec_start, input int rst_at, input string tag);
    int n;
    int ndone;
    n = (lo > hi) ? 0 : hi - lo + 1;
    ndone = 0;
    @(negedge clk);
`ifdef SWAP_RANGE_EN
    sw_lo = lo[DL-1:0]; sw_hi = hi[DL-1:0];
`endif
    start = 1'b1;
    if (hq) begin
      h_req = 1'b1; h_sel = 1'b0; h_we = 1'b1; h_ad = '0; h_wd = 32'hFF;
    end
    #1;
    if (hq) begin
      chk({tag, "_gnt_with_start"}, h_gnt, 0);
      chk({tag, "_cs_with_start"}, cs_a, 0);
    end
    for (int c = 1; c <= 2 * n + 2; c++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, c <= 2 * n + 1);
      chk({tag, "_done"}, done, c == 2 * n + 1);
      chk({tag, "_cs_a"}, cs_a, (c <= 2 * n) || (c == 2 * n + 2 && hq));
      chk({tag, "_we_a"}, we_a, (c <= 2 * n) ? (c % 2 == 0) : (c == 2 * n + 2 && hq));
      chk({tag, "_cs_b"}, cs_b, c <= 2 * n);
      chk({tag, "_we_b"}, we_b, (c <= 2 * n) && (c % 2 == 0));
      chk({tag, "_gnt"}, h_gnt, (c == 2 * n + 2) && hq);
      if (done === 1'b1) ndone++;
      if (c == 1) start = 1'b0;
      if (c == sec_start) start = 1'b1;
      else if (c == sec_start + 1) start = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        chk({tag, "_rst_busy"}, busy, 0);
        chk({tag, "_rst_done"}, done, 0);
        chk({tag, "_rst_cs_a"}, cs_a, 0);
        chk({tag, "_rst_cs_b"}, cs_b, 0);
        rst = 1'b0;
        model_swap(lo, (rst_at / 2 < n) ? rst_at / 2 : n);
        return;
      end
    end
    chk({tag, "_done_count"}, ndone, 1);
    model_swap(lo, n);
    if (hq) begin
      @(negedge clk);
      h_req = 1'b0; h_we = 1'b0;
      chk({tag, "_rvalid_after_wr"}, h_rvalid, 0);
      ref_a[0] = 32'hFF;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    int lo, hi, op;
    logic [WIDTH-1:0] d;
    logic [DL-1:0] a;
    bit s, w;

    rst = 1'b1; start = 1'b0;
    h_req = 1'b1; h_sel = 1'b0; h_we = 1'b1; h_ad = 3'd1; h_wd = 32'h55;
`ifdef SWAP_RANGE_EN
    sw_lo = '0; sw_hi = 3'd7;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_h_gnt", h_gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rvalid", h_rvalid, 0);
    chk("rst_cs_a", cs_a, 0);
    chk("rst_cs_b", cs_b, 0);
    chk("rst_we_a", we_a, 0);
    chk("rst_ad_a", ad_a, 0);
    chk("rst_wd_a", wd_a, 0);
    h_req = 1'b0; h_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Fill table: A[i]=0x10+i, B[i]=0x20+i, then read everything back.
    for (int i = 0; i < DEPTH; i++) begin
      vecs[i]          = '{1'b0, 1'b1, i[DL-1:0], 32'h10 + i, 32'h0};
      vecs[i + 8]      = '{1'b1, 1'b1, i[DL-1:0], 32'h20 + i, 32'h0};
      vecs[i + 16]     = '{1'b0, 1'b0, i[DL-1:0], 32'h0, 32'h10 + i};
      vecs[i + 24]     = '{1'b1, 1'b0, i[DL-1:0], 32'h0, 32'h20 + i};
    end
    for (int v = 0; v < 32; v++)
      host_access(vecs[v].sel, vecs[v].we, vecs[v].ad, vecs[v].wd, vecs[v].exp_rd, "fill");

    // Full swap: done in cycle 17, then A[i]=0x20+i, B[i]=0x10+i.
    run_swap(0, DEPTH - 1, 1'b0, 0, 0, "full");
    for (int i = 0; i < DEPTH; i++) begin
      host_access(1'b0, 1'b0, i[DL-1:0], '0, 32'h20 + i, "full_rd_a");
      host_access(1'b1, 1'b0, i[DL-1:0], '0, 32'h10 + i, "full_rd_b");
    end

    // Host write collides with start, is held through busy, plus a second start at cycle 5.
    run_swap(0, DEPTH - 1, 1'b1, 5, 0, "collide");
    read_all("collide_rd");

    // Reset in cycle 6: words 0..2 exchanged, 3..7 untouched.
    run_swap(0, DEPTH - 1, 1'b0, 0, 6, "midrst");
    read_all("midrst_rd");

`ifdef SWAP_RANGE_EN
    run_swap(2, 4, 1'b0, 0, 0, "range24");
    read_all("range24_rd");
    run_swap(5, 3, 1'b0, 0, 0, "range_empty");
    read_all("range_empty_rd");
`endif

    // Random host traffic and swaps against the array model.
    for (int k = 0; k < 60; k++) begin
      op = $urandom_range(0, 9);
      if (op == 0) begin
`ifdef SWAP_RANGE_EN
        lo = $urandom_range(0, DEPTH - 1);
        hi = $urandom_range(0, DEPTH - 1);
`else
        lo = 0;
        hi = DEPTH - 1;
`endif
        run_swap(lo, hi, 1'b0, 0, 0, "rnd_swap");
      end else begin
        s = 1'($urandom_range(0, 1));
        w = 1'($urandom_range(0, 1));
        a = DL'($urandom_range(0, DEPTH - 1));
        d = $urandom;
        host_access(s, w, a, d, s ? ref_b[a] : ref_a[a], "rnd_host");
      end
    end
    read_all("rnd_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
